ibex_csr_rmw_ctrl: RTL and testbench

Request-side sequencer that sits directly upstream of a single control/status register primitive and turns CSR instructions (read, write, set, clear) into a single-cycle write strobe plus write data for that register. It samples the register's current value and integrity-error flag, performs the read-modify-write with a WARL write mask, and returns the old value on a valid/ready response channel. Read-integrity errors abort the write, are reported per response, and raise a sticky alert.

---
 rtl/ibex_csr_rmw_ctrl.sv | 109 ++++++++++
 tb/tb_ibex_csr_rmw_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_csr_rmw_ctrl.sv
// Read-modify-write sequencer in front of a single CSR primitive: samples the old value at accept,
// issues at most one masked write strobe, then returns the old value and integrity status.
module ibex_csr_rmw_ctrl #(
    parameter int unsigned       Width     = 32,
    parameter logic [Width-1:0]  WriteMask = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [Width-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_error_o,
    output logic             csr_wr_en_o,
    output logic [Width-1:0] csr_wr_data_o,
    input  logic [Width-1:0] csr_rd_data_i,
    input  logic             csr_rd_error_i,
    output logic             alert_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [1:0] OpRead  = 2'd0;
    localparam logic [1:0] OpWrite = 2'd1;
    localparam logic [1:0] OpSet   = 2'd2;
    localparam logic [1:0] OpClear = 2'd3;

    state_e           state;
    logic             accept;
    logic             needs_write;
    logic [Width-1:0] new_value;
    logic [Width-1:0] masked_value;

    // The write value is resolved at accept from the sampled old value, so only the result is kept.
    always_comb begin
        new_value = req_wdata_i;
        case (req_op_i)
            OpSet:   new_value = csr_rd_data_i | req_wdata_i;
            OpClear: new_value = csr_rd_data_i & ~req_wdata_i;
            default: new_value = req_wdata_i;
        endcase
        masked_value = (csr_rd_data_i & ~WriteMask) | (new_value & WriteMask);
    end

    assign accept      = (state == IDLE) && req_valid_i;
    assign needs_write = !csr_rd_error_i &&
                         ((req_op_i == OpWrite) ||
                          ((req_op_i != OpRead) && (|req_wdata_i)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_error_o   <= 1'b0;
            csr_wr_en_o   <= 1'b0;
            csr_wr_data_o <= '0;
            alert_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_rdata_o <= csr_rd_data_i;
                        rsp_error_o <= csr_rd_error_i;
                        alert_o     <= alert_o | csr_rd_error_i;
                        req_ready_o <= 1'b0;
                        if (needs_write) begin
                            state         <= WRITE;
                            csr_wr_en_o   <= 1'b1;
                            csr_wr_data_o <= masked_value;
                        end else begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state         <= RESP;
                    csr_wr_en_o   <= 1'b0;
                    csr_wr_data_o <= '0;
                    rsp_valid_o   <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    req_ready_o   <= 1'b1;
                    rsp_valid_o   <= 1'b0;
                    csr_wr_en_o   <= 1'b0;
                    csr_wr_data_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_csr_rmw_ctrl.sv
// Bench for ibex_csr_rmw_ctrl: one full-mask instance and one low-byte-mask instance share
// the request/response stimulus, each backed by its own emulated register.
module tb_ibex_csr_rmw_ctrl;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;
    localparam logic [31:0] MASK_B  = 32'h0000_00FF;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        csr_rd_error = 1'b0;
    logic [31:0] reg_a = '0;
    logic [31:0] reg_b = '0;

    logic        req_ready_a, rsp_valid_a, rsp_error_a, wr_en_a, alert_a;
    logic [31:0] rsp_rdata_a, wr_data_a;
    logic        req_ready_b, rsp_valid_b, rsp_error_b, wr_en_b, alert_b;
    logic [31:0] rsp_rdata_b, wr_data_b;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_a = '0;
    logic [31:0] model_b = '0;
    logic        model_alert = 1'b0;

    always #5 clk_i = ~clk_i;

    ibex_csr_rmw_ctrl dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready_a),
        .req_op_i(req_op), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata_a), .rsp_error_o(rsp_error_a),
        .csr_wr_en_o(wr_en_a), .csr_wr_data_o(wr_data_a),
        .csr_rd_data_i(reg_a), .csr_rd_error_i(csr_rd_error),
        .alert_o(alert_a)
    );

    ibex_csr_rmw_ctrl #(.Width(32), .WriteMask(MASK_B)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready_b),
        .req_op_i(req_op), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata_b), .rsp_error_o(rsp_error_b),
        .csr_wr_en_o(wr_en_b), .csr_wr_data_o(wr_data_b),
        .csr_rd_data_i(reg_b), .csr_rd_error_i(csr_rd_error),
        .alert_o(alert_b)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] operand;
        logic [31:0] init;
        logic        exp_write;
        logic [31:0] exp_wa;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] rmw_result(input logic [1:0] op, input logic [31:0] operand,
                                               input logic [31:0] old, input logic [31:0] mask);
        logic [31:0] target;
        if (op == OP_WRITE)      target = operand;
        else if (op == OP_SET)   target = old | operand;
        else if (op == OP_CLEAR) target = old & ~operand;
        else                     target = old;
        return (old & ~mask) | (target & mask);
    endfunction

    task automatic setRegister(input logic [31:0] va, input logic [31:0] vb);
        reg_a   = va;
        reg_b   = vb;
        model_a = va;
        model_b = vb;
    endtask

    // One complete transaction starting and ending on a falling edge with the DUTs idle.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] operand, input logic err,
                                 input int hold, input logic exp_write,
                                 input logic [31:0] exp_wa, input logic [31:0] exp_wb);
        checkOutput("idle_req_ready", req_ready_a, 1'b1);
        req_valid    = 1'b1;
        req_op       = op;
        req_wdata    = operand;
        csr_rd_error = err;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid    = 1'b0;
        req_op       = 2'($urandom);
        req_wdata    = $urandom;
        csr_rd_error = 1'b0;
        if (err) model_alert = 1'b1;
        checkOutput("alert_after_accept", alert_a, model_alert);
        checkOutput("busy_req_ready", req_ready_a, 1'b0);
        checkOutput("wr_en_a", wr_en_a, exp_write);
        checkOutput("wr_en_b", wr_en_b, exp_write);
        if (exp_write) begin
            checkOutput("wr_data_a", wr_data_a, exp_wa);
            checkOutput("wr_data_b", wr_data_b, exp_wb);
            checkOutput("rsp_valid_during_write", rsp_valid_a, 1'b0);
            reg_a = wr_data_a;
            reg_b = wr_data_b;
            @(negedge clk_i);
            checkOutput("wr_en_single_cycle", wr_en_a, 1'b0);
        end
        checkOutput("wr_data_zero_when_idle", wr_data_a, 32'h0);
        for (int i = 0; i <= hold; i++) begin
            checkOutput("rsp_valid", rsp_valid_a, 1'b1);
            checkOutput("rsp_rdata_a", rsp_rdata_a, model_a);
            checkOutput("rsp_rdata_b", rsp_rdata_b, model_b);
            checkOutput("rsp_error", rsp_error_a, err);
            checkOutput("resp_req_ready", req_ready_a, 1'b0);
            if (i == hold) rsp_ready = 1'b1;
            @(negedge clk_i);
        end
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_after_handshake", rsp_valid_a, 1'b0);
        checkOutput("req_ready_after_handshake", req_ready_a, 1'b1);
        if (exp_write) begin
            model_a = exp_wa;
            model_b = exp_wb;
        end
    endtask

    initial begin
        vecs[0] = '{OP_READ,  32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 32'h0,          32'h0};
        vecs[1] = '{OP_SET,   32'h0000_000F, 32'h0000_00F0, 1'b1, 32'h0000_00FF, 32'h0000_00FF};
        vecs[2] = '{OP_WRITE, 32'hFFFF_FFFF, 32'h1234_5600, 1'b1, 32'hFFFF_FFFF, 32'h1234_56FF};
        vecs[3] = '{OP_CLEAR, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0,          32'h0};
        vecs[4] = '{OP_CLEAR, 32'h0000_FFFF, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_0000, 32'hA5A5_A500};
        vecs[5] = '{OP_SET,   32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0,          32'h0};
        vecs[6] = '{OP_WRITE, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'hFFFF_FF00};
        vecs[7] = '{OP_SET,   32'h8000_0001, 32'h0000_0100, 1'b1, 32'h8000_0101, 32'h0000_0101};

        repeat (3) @(negedge clk_i);
        checkOutput("reset_req_ready", req_ready_a, 1'b1);
        checkOutput("reset_rsp_valid", rsp_valid_a, 1'b0);
        checkOutput("reset_wr_en", wr_en_a, 1'b0);
        checkOutput("reset_alert", alert_a, 1'b0);
        checkOutput("reset_rdata", rsp_rdata_a, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int v = 0; v < 8; v++) begin
            setRegister(vecs[v].init, vecs[v].init);
            applyStimulus(vecs[v].op, vecs[v].operand, 1'b0, v % 3,
                          vecs[v].exp_write, vecs[v].exp_wa, vecs[v].exp_wb);
        end

        // Integrity error suppresses the write and leaves a sticky alert.
        setRegister(32'h0000_0055, 32'h0000_0055);
        applyStimulus(OP_WRITE, 32'h0000_0001, 1'b1, 0, 1'b0, 32'h0, 32'h0);
        applyStimulus(OP_READ, 32'h0, 1'b0, 1, 1'b0, 32'h0, 32'h0);
        applyStimulus(OP_SET, 32'h0000_0100, 1'b0, 0, 1'b1, 32'h0000_0155, 32'h0000_0055);
        checkOutput("alert_sticky", alert_a, 1'b1);

        // Response backpressure with the request held high; the second accept follows the handshake.
        setRegister(32'h0BAD_F00D, 32'h0BAD_F00D);
        req_valid = 1'b1;
        req_op    = OP_READ;
        req_wdata = 32'h0;
        @(posedge clk_i);
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rsp_valid", rsp_valid_a, 1'b1);
            checkOutput("bp_rdata", rsp_rdata_a, 32'h0BAD_F00D);
            checkOutput("bp_req_ready", req_ready_a, 1'b0);
            @(negedge clk_i);
        end
        rsp_ready = 1'b1;
        @(negedge clk_i);
        rsp_ready = 1'b0;
        checkOutput("bp_idle_req_ready", req_ready_a, 1'b1);
        checkOutput("bp_idle_rsp_valid", rsp_valid_a, 1'b0);
        setRegister(32'h1234_5678, 32'h1234_5678);
        @(negedge clk_i);
        req_valid = 1'b0;
        checkOutput("bp_second_rsp_valid", rsp_valid_a, 1'b1);
        checkOutput("bp_second_rdata", rsp_rdata_a, 32'h1234_5678);
        rsp_ready = 1'b1;
        @(negedge clk_i);
        rsp_ready = 1'b0;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic [1:0]  op;
            logic [31:0] operand;
            logic        err;
            logic        writes;
            op      = 2'($urandom_range(0, 3));
            operand = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            err     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) setRegister($urandom, $urandom);
            writes  = !err && ((op == OP_WRITE) || ((op == OP_SET || op == OP_CLEAR) && operand != 0));
            applyStimulus(op, operand, err, $urandom_range(0, 3), writes,
                          rmw_result(op, operand, model_a, 32'hFFFF_FFFF),
                          rmw_result(op, operand, model_b, MASK_B));
        end

        // Reset during the write cycle drops the strobe and the response.
        if (!model_alert) begin
            applyStimulus(OP_READ, 32'h0, 1'b1, 0, 1'b0, 32'h0, 32'h0);
        end
        setRegister(32'h0000_0000, 32'h0000_0000);
        req_valid = 1'b1;
        req_op    = OP_SET;
        req_wdata = 32'h0000_00F0;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid = 1'b0;
        checkOutput("rst_pre_wr_en", wr_en_a, 1'b1);
        checkOutput("rst_pre_alert", alert_a, 1'b1);
        rst_ni = 1'b0;
        #1;
        model_alert = 1'b0;
        checkOutput("rst_mid_req_ready", req_ready_a, 1'b1);
        checkOutput("rst_mid_rsp_valid", rsp_valid_a, 1'b0);
        checkOutput("rst_mid_rsp_error", rsp_error_a, 1'b0);
        checkOutput("rst_mid_wr_en", wr_en_a, 1'b0);
        checkOutput("rst_mid_wr_data", wr_data_a, 32'h0);
        checkOutput("rst_mid_rdata", rsp_rdata_a, 32'h0);
        checkOutput("rst_mid_alert", alert_a, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        applyStimulus(OP_READ, 32'h0, 1'b0, 0, 1'b0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
